// File: rtl/mac_issue_ctrl.sv
// mac_issue_ctrl
// --------------
// Issues operand triples (A, B, C) to a single MAC over its EN/DONE handshake.
// Triples arrive on a valid/ready stream and wait in a small FIFO. Each triple is
// driven onto the MAC with EN held high until the MAC raises DONE. The MAC result is
// then captured and offered on a valid/ready result port. Only one result may be
// outstanding at a time. If DONE does not arrive within TIMEOUT cycles of EN, the
// triple is abandoned and a sticky error flag is raised.
//
// Ports
//   clk          in   1             clock, rising edge
//   rst          in   1             synchronous active-high reset
//   in_valid     in   1             operand triple valid
//   in_ready     out  1             FIFO can accept a triple
//   in_a/b/c     in   A/B/C width   operand triple
//   mac_en       out  1             MAC enable, high for the whole operation
//   mac_data_*   out  A/B/C width   operands to the MAC, stable while mac_en=1
//   mac_mout     in   OUT_BITWIDTH  MAC result
//   mac_done     in   1             MAC completion
//   out_valid    out  1             result valid
//   out_ready    in   1             downstream accepts result
//   out_data     out  OUT_BITWIDTH  captured MAC result
//   err_timeout  out  1             sticky DONE-timeout flag
module mac_issue_ctrl #(
  parameter int A_BITWIDTH   = 8,
  parameter int B_BITWIDTH   = 8,
  parameter int C_BITWIDTH   = 8,
  parameter int OUT_BITWIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_BITWIDTH-1:0]   in_a,
  input  logic [B_BITWIDTH-1:0]   in_b,
  input  logic [C_BITWIDTH-1:0]   in_c,
  output logic                    mac_en,
  output logic [A_BITWIDTH-1:0]   mac_data_a,
  output logic [B_BITWIDTH-1:0]   mac_data_b,
  output logic [C_BITWIDTH-1:0]   mac_data_c,
  input  logic [OUT_BITWIDTH-1:0] mac_mout,
  input  logic                    mac_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_BITWIDTH-1:0] out_data,
  output logic                    err_timeout
);

  localparam int TRIPLE_W = A_BITWIDTH + B_BITWIDTH + C_BITWIDTH;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W    = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state;
  state_t next_state;

  logic [TRIPLE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                capture;
  logic                abort;
  logic [TMO_W-1:0]    tmo_cnt;

  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // The FIFO never accepts during reset, and there is no bypass path when full:
  // a pop in the same cycle does not make room for a push.
  assign in_ready = !rst && !fifo_full;
  assign push     = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle control strobes. A DONE still high from the previous
  // operation blocks a new issue, as does an unread result.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !mac_done && !out_valid) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        // DONE wins over the timeout if both land on the same cycle.
        if (mac_done) begin
          capture    = 1'b1;
          next_state = DRAIN;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!mac_done) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally over a power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_a, in_b, in_c};
    end
  end

  // MAC drive, timeout counter, result register and error flag. Operands stay on
  // the MAC bus after EN drops until the next issue replaces them.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_en      <= 1'b0;
      mac_data_a  <= '0;
      mac_data_b  <= '0;
      mac_data_c  <= '0;
      tmo_cnt     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (pop) begin
        {mac_data_a, mac_data_b, mac_data_c} <= fifo_mem[rd_ptr];
        mac_en <= 1'b1;
      end else if (capture || abort) begin
        mac_en <= 1'b0;
      end

      if (state == ISSUE) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else if (state == DRAIN && !mac_done) begin
        tmo_cnt <= '0;
      end

      if (capture) begin
        out_data  <= mac_mout;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (abort) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule
